// File: rtl/addsub_pkg.sv
`default_nettype none
// ============================================================================
// Module      : addsub_pkg
// Description : Shared width, saturation constants and word type for the
//               16-bit saturating add/sub datapath.
// Revision    : 1.0 - initial release
// ============================================================================
package addsub_pkg;

  localparam int WIDTH = 16;

  typedef logic [WIDTH-1:0] word_t;

  localparam word_t SAT_POS = 16'h7FFF;
  localparam word_t SAT_NEG = 16'h8000;

endpackage : addsub_pkg
`default_nettype wire

// File: rtl/cla_4bit.sv
`default_nettype none
// ============================================================================
// Module      : cla_4bit
// Description : 4-bit carry-lookahead slice exporting group propagate and
//               group generate for the second lookahead level.
// Revision    : 1.0 - initial release
// ============================================================================
module cla_4bit (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] s,
  output logic       P,
  output logic       G
);

  logic [3:0] w_p;
  logic [3:0] w_g;
  logic [3:1] w_c;

  assign w_p = a ^ b;
  assign w_g = a & b;

  assign w_c[1] = w_g[0] | (w_p[0] & cin);
  assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & cin);
  assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                | (w_p[2] & w_p[1] & w_p[0] & cin);

  assign s = w_p ^ {w_c[3], w_c[2], w_c[1], cin};

  assign P = &w_p;
  assign G = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
           | (w_p[3] & w_p[2] & w_p[1] & w_g[0]);

endmodule : cla_4bit
`default_nettype wire

// File: rtl/addsub_carry_look_16bit.sv
`default_nettype none
// ============================================================================
// Module      : addsub_carry_look_16bit
// Description : 16-bit signed saturating adder/subtractor built from four
//               cla_4bit slices and a group lookahead unit, plus a sticky
//               overflow flag. Define ADDSUB_OUTREG_EN to register Sum/Ovfl.
// Revision    : 1.0 - initial release
// ============================================================================
module addsub_carry_look_16bit
  import addsub_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [WIDTH-1:0]  A,
  input  logic [WIDTH-1:0]  B,
  input  logic              sub,
  output logic [WIDTH-1:0]  Sum,
  output logic              Ovfl,
  output logic              ovfl_sticky
);

  localparam int c_ngrp = WIDTH / 4;

  word_t             w_bx;
  word_t             w_raw;
  word_t             w_sum;
  logic              w_ovfl;
  logic [c_ngrp-1:0] w_gp;
  logic [c_ngrp-1:0] w_gg;
  logic [c_ngrp-1:0] w_cin;
  logic              w_unused_c16;
  logic              r_sticky;

  // Subtraction is A + ~B + 1: the inversion and the carry-in share sub.
  assign w_bx = B ^ {WIDTH{sub}};

  generate
    for (genvar gi = 0; gi < c_ngrp; gi++) begin : g_grp
      cla_4bit u_cla (
        .a   (A[4*gi +: 4]),
        .b   (w_bx[4*gi +: 4]),
        .cin (w_cin[gi]),
        .s   (w_raw[4*gi +: 4]),
        .P   (w_gp[gi]),
        .G   (w_gg[gi])
      );
    end
  endgenerate

  // Second-level lookahead: every group carry is a flat sum of products.
  assign w_cin[0] = sub;
  assign w_cin[1] = w_gg[0] | (w_gp[0] & sub);
  assign w_cin[2] = w_gg[1] | (w_gp[1] & w_gg[0]) | (w_gp[1] & w_gp[0] & sub);
  assign w_cin[3] = w_gg[2] | (w_gp[2] & w_gg[1]) | (w_gp[2] & w_gp[1] & w_gg[0])
                  | (w_gp[2] & w_gp[1] & w_gp[0] & sub);

  // Carry out of bit 15 has no consumer; kept only to close the group-3 terms.
  assign w_unused_c16 = w_gg[3] | (w_gp[3] & w_cin[3]);

  assign w_ovfl = (A[WIDTH-1] == w_bx[WIDTH-1]) && (w_raw[WIDTH-1] != A[WIDTH-1]);
  assign w_sum  = !w_ovfl       ? w_raw   :
                  A[WIDTH-1]    ? SAT_NEG : SAT_POS;

`ifdef ADDSUB_OUTREG_EN
  word_t r_sum;
  logic  r_ovfl;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sum  <= '0;
      r_ovfl <= 1'b0;
    end else begin
      r_sum  <= w_sum;
      r_ovfl <= w_ovfl;
    end
  end

  assign Sum  = r_sum;
  assign Ovfl = r_ovfl;
`else
  assign Sum  = w_sum;
  assign Ovfl = w_ovfl;
`endif

  always_ff @(posedge clk) begin
    if (rst) r_sticky <= 1'b0;
    else     r_sticky <= r_sticky | Ovfl;
  end

  assign ovfl_sticky = r_sticky;

endmodule : addsub_carry_look_16bit
`default_nettype wire

// File: tb/tb_addsub_carry_look_16bit.sv
`default_nettype none
// ============================================================================
// Module      : tb_addsub_carry_look_16bit
// Description : Self-checking bench for the saturating add/sub datapath,
//               directed vectors plus randomised model comparison.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_addsub_carry_look_16bit;
  import addsub_pkg::*;

  logic  clk = 1'b0;
  logic  rst = 1'b1;
  word_t A   = '0;
  word_t B   = '0;
  logic  sub = 1'b0;
  word_t Sum;
  logic  Ovfl;
  logic  ovfl_sticky;

  int total = 0;
  int bad   = 0;

  addsub_carry_look_16bit dut (
    .clk         (clk),
    .rst         (rst),
    .A           (A),
    .B           (B),
    .sub         (sub),
    .Sum         (Sum),
    .Ovfl        (Ovfl),
    .ovfl_sticky (ovfl_sticky)
  );

  always #5 clk = ~clk;

  // Apply operands and return once Sum/Ovfl for them are observable.
  task automatic drive(input word_t a, input word_t b, input logic s);
    @(negedge clk);
    A = a; B = b; sub = s;
`ifdef ADDSUB_OUTREG_EN
    @(posedge clk);
`endif
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(16'h7FFF, 16'h0001, 1'b0);
    @(posedge clk); #1;
    total++;
    if (ovfl_sticky !== 1'b0) begin
      bad++; $display("FAIL reset_sticky: got %b want 0", ovfl_sticky);
    end
`ifdef ADDSUB_OUTREG_EN
    total++;
    if (Sum !== 16'h0000 || Ovfl !== 1'b0) begin
      bad++; $display("FAIL reset_outreg: got Sum=%h Ovfl=%b want 0000/0", Sum, Ovfl);
    end
`endif
    rst = 1'b0;
  endtask

  task automatic test_vectors(input string name, input logic s,
                              input word_t va [4], input word_t vb [4],
                              input word_t vs [4], input logic vo [4]);
    for (int i = 0; i < 4; i++) begin
      drive(va[i], vb[i], s);
      total++;
      if (Sum !== vs[i] || Ovfl !== vo[i]) begin
        bad++;
        $display("FAIL %s[%0d]: A=%h B=%h got Sum=%h Ovfl=%b want Sum=%h Ovfl=%b",
                 name, i, va[i], vb[i], Sum, Ovfl, vs[i], vo[i]);
      end
    end
  endtask

  task automatic test_add();
    word_t va [4] = '{16'h1234, 16'h7FFF, 16'h8000, 16'h0001};
    word_t vb [4] = '{16'h0F0F, 16'h0001, 16'hFFFF, 16'hFFFE};
    word_t vs [4] = '{16'h2143, 16'h7FFF, 16'h8000, 16'hFFFF};
    logic  vo [4] = '{1'b0,     1'b1,     1'b1,     1'b0};
    test_vectors("add", 1'b0, va, vb, vs, vo);
  endtask

  task automatic test_sub();
    word_t va [4] = '{16'h0000, 16'h8000, 16'hFFFF, 16'h8000};
    word_t vb [4] = '{16'h8000, 16'h0001, 16'h0001, 16'h8000};
    word_t vs [4] = '{16'h7FFF, 16'h8000, 16'hFFFE, 16'h0000};
    logic  vo [4] = '{1'b1,     1'b1,     1'b0,     1'b0};
    test_vectors("sub", 1'b1, va, vb, vs, vo);
  endtask

  task automatic test_carry();
    word_t va [4] = '{16'h0FFF, 16'hFFFF, 16'h00FF, 16'h0F0F};
    word_t vb [4] = '{16'h0001, 16'h0001, 16'h0001, 16'h00F1};
    word_t vs [4] = '{16'h1000, 16'h0000, 16'h0100, 16'h1000};
    logic  vo [4] = '{1'b0,     1'b0,     1'b0,     1'b0};
    test_vectors("carry", 1'b0, va, vb, vs, vo);
  endtask

  task automatic test_sticky();
    rst = 1'b1;
    drive(16'h0000, 16'h0000, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    total++;
    if (ovfl_sticky !== 1'b0) begin
      bad++; $display("FAIL sticky_clear: got %b want 0", ovfl_sticky);
    end
    drive(16'h7FFF, 16'h0001, 1'b0);
    @(posedge clk); #1;
    total++;
    if (ovfl_sticky !== 1'b1) begin
      bad++; $display("FAIL sticky_set: got %b want 1", ovfl_sticky);
    end
    drive(16'h0001, 16'h0001, 1'b0);
    @(posedge clk); #1;
    total++;
    if (ovfl_sticky !== 1'b1) begin
      bad++; $display("FAIL sticky_hold: got %b want 1", ovfl_sticky);
    end
    rst = 1'b1;
    drive(16'h7FFF, 16'h0001, 1'b0);
    @(posedge clk); #1;
    total++;
    if (ovfl_sticky !== 1'b0) begin
      bad++; $display("FAIL sticky_rst_wins: got %b want 0", ovfl_sticky);
    end
    rst = 1'b0;
  endtask

  task automatic test_random();
    word_t ra, rb, es;
    logic  eo;
    int    r;
    for (int i = 0; i < 200; i++) begin
      ra = word_t'($urandom);
      rb = word_t'($urandom);
      if (i % 4 == 0) ra[14:8] = '1;  // bias toward the overflow region
      r = (i < 100) ? int'($signed(ra)) + int'($signed(rb))
                    : int'($signed(ra)) - int'($signed(rb));
      if (r > 32767)       begin es = 16'h7FFF; eo = 1'b1; end
      else if (r < -32768) begin es = 16'h8000; eo = 1'b1; end
      else                 begin es = word_t'(r); eo = 1'b0; end
      drive(ra, rb, (i >= 100));
      total++;
      if (Sum !== es || Ovfl !== eo) begin
        bad++;
        $display("FAIL random[%0d]: A=%h B=%h sub=%b got Sum=%h Ovfl=%b want Sum=%h Ovfl=%b",
                 i, ra, rb, sub, Sum, Ovfl, es, eo);
      end
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_carry();
    test_sticky();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_addsub_carry_look_16bit
`default_nettype wire
